// File: rtl/dmem_pkg.sv
// Shared encodings and types for the data-memory responder (dmem_responder).
package dmem_pkg;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;
  localparam logic [1:0] LEN_RSVD = 2'b11;

  // Width of the wait-state counter; WAIT_STATES may range 0..15.
  localparam int WS_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_if.sv
// CPU load/store port: the CPU drives the request fields, the responder returns ack/rdata/err.
interface dmem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  len;
  logic        ack;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, we, addr, wdata, len, input ack, rdata, err);
  modport slave  (input req, we, addr, wdata, len, output ack, rdata, err);
endinterface

// File: rtl/dmem_lane_align.sv
// Little-endian lane merge for stores and lane extract/extend for loads.
// With DMEM_ALIGN_CHECK_EN defined, misaligned or reserved-length accesses raise misalign.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  len,
  output logic [31:0] store_word,
  output logic [31:0] load_word,
  output logic        misalign
);

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic uns);
    logic signed [7:0]  sb;
    logic signed [31:0] s32;
    sb  = b;
    s32 = sb;
    return uns ? {24'h0, b} : s32;
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic uns);
    logic signed [15:0] sh;
    logic signed [31:0] s32;
    sh  = h;
    s32 = sh;
    return uns ? {16'h0, h} : s32;
  endfunction

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    byte_sh    = {byte_off, 3'b000};
    half_sh    = {byte_off[1], 4'b0000};
    ld_byte    = old_word[byte_sh +: 8];
    ld_half    = old_word[half_sh +: 16];
    store_word = old_word;
    load_word  = old_word;
    case (len[1:0])
      LEN_BYTE: begin
        store_word[byte_sh +: 8] = wdata[7:0];
        load_word                = ext8(ld_byte, len[2]);
      end
      LEN_HALF: begin
        store_word[half_sh +: 16] = wdata[15:0];
        load_word                 = ext16(ld_half, len[2]);
      end
      // Word and reserved length both behave as a full-word access.
      default: begin
        store_word = wdata;
        load_word  = old_word;
      end
    endcase
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = ((len[1:0] == LEN_HALF) && byte_off[0]) ||
                    ((len[1:0] == LEN_WORD) && (byte_off != 2'b00)) ||
                    (len[1:0] == LEN_RSVD);
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_STATES cycles before ack, byte/half/word
// stores into a word array and extended loads. DMEM_ALIGN_CHECK_EN enables error responses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 128,
  parameter int ADDR_W      = 7,
  parameter int WAIT_STATES = 2
) (
  input  logic  clock,
  input  logic  rstn,
  dmem_if.slave bus
);

  localparam logic [WS_W-1:0] CNT_INIT = (WAIT_STATES > 0) ? WS_W'(WAIT_STATES - 1) : '0;

  state_e            state_q, state_d;
  logic [WS_W-1:0]   cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        len_q, len_d;
  logic              latch_en, access_en, mem_we;
  logic              cur_we;
  logic [31:0]       cur_addr, cur_wdata;
  logic [2:0]        cur_len;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       old_word, store_word, load_word;
  logic              misalign;
  logic              unused_addr_hi;
  logic [31:0]       mem_q [DEPTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch_en  = 1'b0;
    access_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          latch_en = 1'b1;
          if (WAIT_STATES == 0) begin
            access_en = 1'b1;
            state_d   = RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          access_en = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the access happens on the accept edge, so use the live bus fields.
  always_comb begin
    if (state_q == IDLE) begin
      cur_we    = bus.we;
      cur_addr  = bus.addr;
      cur_wdata = bus.wdata;
      cur_len   = bus.len;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_len   = len_q;
    end
  end

  assign idx            = cur_addr[ADDR_W+1:2];
  assign old_word       = mem_q[idx];
  assign unused_addr_hi = ^cur_addr[31:ADDR_W+2];

  dmem_lane_align u_align (
    .old_word   (old_word),
    .wdata      (cur_wdata),
    .byte_off   (cur_addr[1:0]),
    .len        (cur_len),
    .store_word (store_word),
    .load_word  (load_word),
    .misalign   (misalign)
  );

  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    len_d   = len_q;
    if (latch_en) begin
      we_d    = bus.we;
      addr_d  = bus.addr;
      wdata_d = bus.wdata;
      len_d   = bus.len;
    end
  end

  // Gating with rstn keeps a store from committing on an edge that arrives during reset.
  always_comb begin
    mem_we  = access_en & cur_we & ~misalign & rstn;
    ack_d   = access_en;
    err_d   = access_en & misalign;
    rdata_d = rdata_q;
    if (access_en) begin
      if (misalign)    rdata_d = '0;
      else if (!cur_we) rdata_d = load_word;
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clock) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    len_q   <= len_d;
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem_q[idx] <= store_word;
  end

  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the CPU's load/store port.
- Accepts one request at a time over a req/ack handshake, inserts configurable wait states, and commits byte/half/word stores into a word-organised array.
- Returns aligned, sign- or zero-extended load data.
- Sits beside the CPU in the SOPC top as the slave end of the CPU's MemWrite / address / WriteMemData / length interface, replacing the zero-latency combinational data memory.

Parameters:
- DEPTH, 128, number of 32-bit words; power of two.
- ADDR_W, 7, word-index width = log2(DEPTH); word index = addr[ADDR_W+1:2].
- WAIT_STATES, 2, extra cycles between request accept and ack; 0..15 legal.

Ports:
- clock  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- req  in  1  request valid; held high, with all request fields stable, until ack
- we  in  1  1 = store, 0 = load
- addr  in  32  byte address
- wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- len  in  3  [1:0]: 00 byte, 01 half, 10 word, 11 reserved; [2]: 1 = unsigned load
- ack  out  1  one-cycle registered completion pulse
- rdata  out  32  load result, valid while ack=1; holds its value until the next load ack
- err  out  1  error flag, coincident with ack (see Optional Feature)

Behaviour:
- Interface polarity: one clock; reset is asynchronous and active-low. Ports are named clock and rstn.
- Reset state:
  - state=IDLE, cnt=0.
  - ack=0, err=0, rdata=32'h0.
  - Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If req=1, latch we/addr/wdata/len.
  - If WAIT_STATES=0, perform the access at this edge and go to RESP.
  - Otherwise load cnt=WAIT_STATES-1 and go to WAIT.
- WAIT:
  - If cnt=0, perform the access at this edge and go to RESP.
  - Otherwise decrement cnt.
  - req is ignored while in WAIT.
- RESP: ack=1 for exactly one cycle, then go to IDLE unconditionally.
- Latency: req first high in IDLE at cycle 0 gives ack=1 in cycle WAIT_STATES+1.
- Back-to-back requests: req still high in the cycle after RESP counts as a new request. Minimum spacing is therefore WAIT_STATES+2 cycles per access.
- Store, little-endian lane merge (read-modify-write of the indexed word):
  - byte: lane addr[1:0] gets wdata[7:0].
  - half: lane addr[1] gets wdata[15:0].
  - word: full 32-bit write.
  - Unwritten lanes are preserved.
- Load:
  - Extract the byte at lane addr[1:0] or the half at lane addr[1].
  - Sign-extend if len[2]=0, zero-extend if len[2]=1; word loads ignore len[2].
  - rdata is registered at the access edge.
  - A store leaves rdata unchanged.
- Addressing: addr bits above ADDR_W+1 are ignored (index wraps modulo DEPTH).
- Reset mid-operation:
  - Returns to IDLE immediately; ack drops asynchronously.
  - A store not yet at its access edge is dropped. A store already committed stays committed.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined:
  - A half with addr[0]=1, a word with addr[1:0]!=0, or len[1:0]=11 is an error access.
  - An error access completes with normal latency, err=1 with ack, no array write, rdata=32'h0.
- Undefined:
  - err is tied to 0.
  - Offending low address bits are ignored (half uses addr[1] only; word ignores addr[1:0]).
  - len[1:0]=11 is treated as word.

Decomposition:
- Package dmem_pkg:
  - len encodings LEN_BYTE=2'b00, LEN_HALF=2'b01, LEN_WORD=2'b10, LEN_RSVD=2'b11.
  - FSM state enum (IDLE, WAIT, RESP).
  - WAIT_STATES width constant (4 bits).
- Sub-module dmem_lane_align (combinational):
  - Inputs: old word, wdata, addr[1:0], len.
  - Outputs: merged store word, extracted/extended load word, misalign flag.
  - The responder top holds only FSM, counter, array and output registers.

Test Plan:
- Reset, then store word 0x12345678 at 0x10, then load word at 0x10 with WAIT_STATES=2 -> ack in cycle 3 after req, rdata=0x12345678, err=0.
- Store byte 0xAB at 0x11, then load word 0x10 -> 0x1234AB78. Load byte signed at 0x11 -> 0xFFFFFFAB. Load byte unsigned -> 0x000000AB.
- Store half 0x8001 at 0x12, then load half signed at 0x12 -> 0xFFFF8001. Load half unsigned -> 0x00008001. Load word 0x10 -> 0x8001AB78.
- WAIT_STATES=0 with req held high over three loads -> ack in cycles 1, 3, 5; rdata updates on each ack.
- Assert rstn=0 while in WAIT during a store of 0xDEADBEEF to 0x20 -> ack stays 0, FSM returns to IDLE, a later load at 0x20 returns the prior contents.
- With DMEM_ALIGN_CHECK_EN, load word at 0x13 -> ack=1, err=1, rdata=0, array unchanged. Without the macro -> returns the word at 0x10, err=0.
